// File: rtl/dpram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpram_pkg;

    // Clear sequencer states: scrub the array, then serve requests.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dpram_state_t;

    // Number of byte lanes in a word.
    function automatic int nbytes(input int dwidth);
        return dwidth / 8;
    endfunction

    // Byte enables are big-endian: the enable for lane j sits at the opposite end of the vector.
    function automatic int lane_en_idx(input int nb, input int lane);
        return nb - 1 - lane;
    endfunction

    // Array index width; never zero so single-word memories still elaborate.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dpram_clear_fsm.sv
// Post-reset scrub sequencer: walks every word once, one word per cycle.
// Latency: busy stays high for exactly NUM_WORDS cycles after reset release.
// Backpressure: none; while busy the top drops all external requests.
module dpram_clear_fsm
    import dpram_pkg::*;
#(
    parameter  int NUM_WORDS = 1024,
    localparam int IW        = idx_width(NUM_WORDS)
) (
    input  logic          clk,
    input  logic          resetn,
    output logic          busy,
    output logic [IW-1:0] clr_addr
);

    dpram_state_t state;

    // Advance the scrub address each cycle; leave CLEAR after the last word is written.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_CLEAR;
            busy     <= 1'b1;
            clr_addr <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_addr == IW'(NUM_WORDS - 1)) begin
                        state <= ST_READY;
                        busy  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + IW'(1);
                    end
                end
                ST_READY: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dpram_byteen.sv
// True dual-port RAM, per-byte big-endian write enables, read-first, post-reset scrub.
// Latency: read data + rdvalid 1 cycle after request, 2 with DPRAM_OUTREG_EN defined.
// Backpressure: none; requests presented while busy (scrubbing) are silently dropped.
module dpram_byteen
    import dpram_pkg::*;
#(
    parameter  int                AWIDTH    = 10,
    parameter  int                NUM_WORDS = 1024,
    parameter  int                DWIDTH    = 32,
    parameter  logic [DWIDTH-1:0] CLEAR_VAL = '0,
    localparam int                NBYTES    = nbytes(DWIDTH),
    localparam int                IW        = idx_width(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [AWIDTH-1:0] address_a,
    input  logic              wren_a,
    input  logic [NBYTES-1:0] byteen_a,
    input  logic [DWIDTH-1:0] data_a,
    output logic [DWIDTH-1:0] out_a,
    output logic              rdvalid_a,
    input  logic [AWIDTH-1:0] address_b,
    input  logic              wren_b,
    input  logic [NBYTES-1:0] byteen_b,
    input  logic [DWIDTH-1:0] data_b,
    output logic [DWIDTH-1:0] out_b,
    output logic              rdvalid_b,
    output logic              busy,
    output logic              collision
);

    logic [DWIDTH-1:0] mem [NUM_WORDS];

    logic [IW-1:0]     clr_addr;
    logic              active;
    logic              a_inrng, b_inrng;
    logic [IW-1:0]     a_idx, b_idx;
    logic              wa_en, wb_en;
    logic [IW-1:0]     wa_idx;
    logic [DWIDTH-1:0] wa_dat;
    logic [NBYTES-1:0] wa_lane, wb_lane;
    logic [DWIDTH-1:0] rd_a_dat, rd_b_dat;
    logic              rd_a_vld, rd_b_vld;

    dpram_clear_fsm #(.NUM_WORDS(NUM_WORDS)) u_clear (
        .clk      (clk),
        .resetn   (resetn),
        .busy     (busy),
        .clr_addr (clr_addr)
    );

    assign active  = resetn & ~busy;
    assign a_inrng = {1'b0, address_a} < (AWIDTH + 1)'(NUM_WORDS);
    assign b_inrng = {1'b0, address_b} < (AWIDTH + 1)'(NUM_WORDS);
    assign a_idx   = address_a[IW-1:0];
    assign b_idx   = address_b[IW-1:0];

    // Port A write path is shared with the scrubber; out-of-range writes are discarded.
    assign wa_en  = resetn & (busy | (wren_a & a_inrng));
    assign wb_en  = active & wren_b & b_inrng;
    assign wa_idx = busy ? clr_addr : a_idx;
    assign wa_dat = busy ? CLEAR_VAL : data_a;

    // Map big-endian byte enables onto little-endian data lanes.
    always_comb begin
        wa_lane = '0;
        wb_lane = '0;
        for (int j = 0; j < NBYTES; j++) begin
            wa_lane[j] = busy | byteen_a[lane_en_idx(NBYTES, j)];
            wb_lane[j] = byteen_b[lane_en_idx(NBYTES, j)];
        end
    end

    // Per-lane array writes; port A is applied last so it wins lanes both ports enable.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NBYTES; j++) begin
            if (wb_en && wb_lane[j]) mem[b_idx][8*j +: 8] <= data_b[8*j +: 8];
        end
        for (int j = 0; j < NBYTES; j++) begin
            if (wa_en && wa_lane[j]) mem[wa_idx][8*j +: 8] <= wa_dat[8*j +: 8];
        end
    end

    // Registered read-first outputs; a write holds the last read data and drops valid.
    always_ff @(posedge clk) begin
        if (!resetn || busy) begin
            rd_a_dat  <= '0;
            rd_a_vld  <= 1'b0;
            rd_b_dat  <= '0;
            rd_b_vld  <= 1'b0;
            collision <= 1'b0;
        end else begin
            rd_a_vld <= ~wren_a;
            rd_b_vld <= ~wren_b;
            if (!wren_a) rd_a_dat <= a_inrng ? mem[a_idx] : '0;
            if (!wren_b) rd_b_dat <= b_inrng ? mem[b_idx] : '0;
            collision <= wren_a & wren_b & a_inrng & b_inrng & (address_a == address_b);
        end
    end

`ifdef DPRAM_OUTREG_EN
    logic [DWIDTH-1:0] pipe_a_dat, pipe_b_dat;
    logic              pipe_a_vld, pipe_b_vld;

    // Extra output stage for timing; data and valid travel together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pipe_a_dat <= '0;
            pipe_a_vld <= 1'b0;
            pipe_b_dat <= '0;
            pipe_b_vld <= 1'b0;
        end else begin
            pipe_a_dat <= rd_a_dat;
            pipe_a_vld <= rd_a_vld;
            pipe_b_dat <= rd_b_dat;
            pipe_b_vld <= rd_b_vld;
        end
    end

    assign out_a     = pipe_a_dat;
    assign rdvalid_a = pipe_a_vld;
    assign out_b     = pipe_b_dat;
    assign rdvalid_b = pipe_b_vld;
`else
    assign out_a     = rd_a_dat;
    assign rdvalid_a = rd_a_vld;
    assign out_b     = rd_b_dat;
    assign rdvalid_b = rd_b_vld;
`endif

endmodule

// File: tb/tb_dpram_byteen.sv
// Directed bench for dpram_byteen: 16-word instance, scrub value 0xA5A5A5A5.
// Latency: follows DPRAM_OUTREG_EN (1 or 2 cycles).
// Backpressure: n/a.
module tb_dpram_byteen;

`ifdef DPRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [31:0] CV = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [4:0]  address_a = '0, address_b = '0;
    logic        wren_a = 1'b0, wren_b = 1'b0;
    logic [3:0]  byteen_a = '0, byteen_b = '0;
    logic [31:0] data_a = '0, data_b = '0;
    logic [31:0] out_a, out_b;
    logic        rdvalid_a, rdvalid_b, busy, collision;

    int total = 0;
    int bad   = 0;
    int cnt;

    dpram_byteen #(
        .AWIDTH(5), .NUM_WORDS(16), .DWIDTH(32), .CLEAR_VAL(CV)
    ) dut (
        .clk(clk), .resetn(resetn),
        .address_a(address_a), .wren_a(wren_a), .byteen_a(byteen_a), .data_a(data_a),
        .out_a(out_a), .rdvalid_a(rdvalid_a),
        .address_b(address_b), .wren_b(wren_b), .byteen_b(byteen_b), .data_b(data_b),
        .out_b(out_b), .rdvalid_b(rdvalid_b),
        .busy(busy), .collision(collision)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wren_a = 1'b0; wren_b = 1'b0; byteen_a = '0; byteen_b = '0;
    endtask

    task automatic rd_a(input string tag, input logic [4:0] a, input logic [31:0] exp);
        address_a = a; wren_a = 1'b0;
        repeat (LAT) tick();
        chk(tag, out_a, exp);
        chk({tag, "_vld"}, {31'd0, rdvalid_a}, 32'd1);
    endtask

    task automatic rd_b(input string tag, input logic [4:0] a, input logic [31:0] exp);
        address_b = a; wren_b = 1'b0;
        repeat (LAT) tick();
        chk(tag, out_b, exp);
        chk({tag, "_vld"}, {31'd0, rdvalid_b}, 32'd1);
    endtask

    task automatic wr_a(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        address_a = a; data_a = d; byteen_a = be; wren_a = 1'b1;
        tick();
        wren_a = 1'b0; byteen_a = '0;
        repeat (LAT - 1) tick();
    endtask

    task automatic wr_b(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        address_b = a; data_b = d; byteen_b = be; wren_b = 1'b1;
        tick();
        wren_b = 1'b0; byteen_b = '0;
        repeat (LAT - 1) tick();
    endtask

    // Count cycles of busy after release, driving writes that must be ignored.
    task automatic count_busy(output int n);
        n = 0;
        address_a = 5'd2; data_a = 32'h0; byteen_a = 4'hF; wren_a = 1'b1;
        address_b = 5'd12; data_b = 32'h0; byteen_b = 4'hF; wren_b = 1'b1;
        while (busy === 1'b1 && n < 64) begin
            tick();
            n++;
            if (n == 5) begin
                chk("busy_vld_a", {31'd0, rdvalid_a}, 32'd0);
                chk("busy_out_b", out_b, 32'd0);
            end
        end
        idle();
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_vld_b", {31'd0, rdvalid_b}, 32'd0);
        chk("rst_coll", {31'd0, collision}, 32'd0);

        // Scrub after reset release
        resetn = 1'b1;
        count_busy(cnt);
        chk("clr_cycles", cnt, 32'd16);
        for (int i = 0; i < 16; i++) rd_a("clr_rd", 5'(i), CV);
        rd_b("clr_rd_b", 5'd12, CV);

        // Byte-enabled write, big-endian enables: 0101 writes lanes 3 and 1
        wr_a(5'd3, 32'h11223344, 4'hF);
        rd_a("base3", 5'd3, 32'h11223344);
        wr_a(5'd3, 32'hDEADBEEF, 4'b0101);
        chk("wr_novld", {31'd0, rdvalid_a}, 32'd0);
        chk("wr_hold", out_a, 32'h11223344);
        rd_a("be0101", 5'd3, 32'hDE22BE44);

        // Zero enables: write with no effect
        wr_a(5'd3, 32'h0, 4'b0000);
        rd_a("be0000", 5'd3, 32'hDE22BE44);

        // Read-first, A writes / B reads
        wr_a(5'd5, 32'h01020304, 4'hF);
        address_a = 5'd5; data_a = 32'hCAFEF00D; byteen_a = 4'hF; wren_a = 1'b1;
        address_b = 5'd5; wren_b = 1'b0;
        tick();
        idle();
        repeat (LAT - 1) tick();
        chk("rf_b_old", out_b, 32'h01020304);
        chk("rf_b_vld", {31'd0, rdvalid_b}, 32'd1);
        rd_b("rf_b_new", 5'd5, 32'hCAFEF00D);

        // Read-first, B writes / A reads
        address_b = 5'd5; data_b = 32'h55667788; byteen_b = 4'hF; wren_b = 1'b1;
        address_a = 5'd5; wren_a = 1'b0;
        tick();
        idle();
        repeat (LAT - 1) tick();
        chk("rf_a_old", out_a, 32'hCAFEF00D);
        rd_a("rf_a_new", 5'd5, 32'h55667788);

        // Both write @7: A lanes 0,1; B lanes 1,2; A wins lane 1
        wr_a(5'd7, 32'h12345678, 4'hF);
        address_a = 5'd7; data_a = 32'hAAAAAAAA; byteen_a = 4'b1100; wren_a = 1'b1;
        address_b = 5'd7; data_b = 32'hBBBBBBBB; byteen_b = 4'b0110; wren_b = 1'b1;
        tick();
        idle();
        chk("coll_hi", {31'd0, collision}, 32'd1);
        tick();
        chk("coll_lo", {31'd0, collision}, 32'd0);
        rd_a("merge7", 5'd7, 32'h12BBAAAA);

        // Both write different addresses: no collision
        address_a = 5'd8; data_a = 32'h88888888; byteen_a = 4'hF; wren_a = 1'b1;
        address_b = 5'd9; data_b = 32'h99999999; byteen_b = 4'hF; wren_b = 1'b1;
        tick();
        idle();
        chk("coll_diff", {31'd0, collision}, 32'd0);
        rd_a("diff8", 5'd8, 32'h88888888);
        rd_b("diff9", 5'd9, 32'h99999999);

        // Out-of-range: reads give 0 with valid, writes do not alias into the array
        rd_a("oor_rd_a", 5'd20, 32'h0);
        rd_b("oor_rd_b", 5'd20, 32'h0);
        wr_a(5'd20, 32'hFFFFFFFF, 4'hF);
        wr_b(5'd20, 32'hEEEEEEEE, 4'hF);
        rd_a("oor_alias", 5'd4, CV);

        // Reset in READY rescrubs; reset again mid-clear at address 8
        wr_a(5'd12, 32'h0BADF00D, 4'hF);
        rd_a("pre_rst12", 5'd12, 32'h0BADF00D);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        repeat (8) tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        resetn = 1'b0;
        tick();
        chk("rerst_busy", {31'd0, busy}, 32'd1);
        resetn = 1'b1;
        count_busy(cnt);
        chk("reclr_cycles", cnt, 32'd16);
        rd_a("rescrub12", 5'd12, CV);
        rd_a("rescrub2", 5'd2, CV);
        rd_b("rescrub15", 5'd15, CV);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
